// File: rtl/tuple_unpack_if.sv
// tuple_unpack_if
//   Bundles the two valid/ready streams and status outputs of tuple_unpack.
//   Parameters must match those of the tuple_unpack instance it is bound to.
// Signals
//   tuple_valid/tuple_ready/tuple_in : packed tuple input stream
//   out_valid/out_ready              : decoded word output stream
//   syn_cnt, pkt_cnt                 : verbatim count fields
//   mean, variance                   : rebuilt fixed-point values (SCALING fraction bits)
//   fmt_err                          : mean field had bits above DATAIN_WIDTH set
//   tuple_count, err_count           : saturating accept / format-error counters
// Modports
//   master : producer of tuples and consumer of decoded words (e.g. testbench)
//   slave  : tuple_unpack itself
interface tuple_unpack_if #(
    parameter int SCALING         = 32,
    parameter int DATAIN_WIDTH    = 11,
    parameter int RES_SHORT_WIDTH = 24,
    parameter int TUPLE_WIDTH     = 4 * RES_SHORT_WIDTH,
    parameter int CNT_WIDTH       = 32
);
    logic                                  tuple_valid;
    logic                                  tuple_ready;
    logic [TUPLE_WIDTH-1:0]                tuple_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [RES_SHORT_WIDTH-1:0]            syn_cnt;
    logic [RES_SHORT_WIDTH-1:0]            pkt_cnt;
    logic [DATAIN_WIDTH+SCALING:0]         mean;
    logic [2*DATAIN_WIDTH+SCALING:0]       variance;
    logic                                  fmt_err;
    logic [CNT_WIDTH-1:0]                  tuple_count;
    logic [CNT_WIDTH-1:0]                  err_count;

    modport master (
        output tuple_valid, tuple_in, out_ready,
        input  tuple_ready, out_valid, syn_cnt, pkt_cnt, mean, variance,
               fmt_err, tuple_count, err_count
    );

    modport slave (
        input  tuple_valid, tuple_in, out_ready,
        output tuple_ready, out_valid, syn_cnt, pkt_cnt, mean, variance,
               fmt_err, tuple_count, err_count
    );
endinterface

// File: rtl/tuple_unpack.sv
// tuple_unpack
//   Receive side of the Welford stats tuple. Splits each packed
//   {syn_cnt, pkt_cnt, mean, variance} word into fields, rebuilds mean and
//   variance at full fixed-point scale, flags malformed mean fields and keeps
//   saturating tuple/error counters. Words pass through a 2-entry skid buffer
//   so the input side sees a registered ready while sustaining 1 word/cycle.
// Ports
//   clk    : clock
//   resetn : asynchronous active-low reset; discards any buffered words
//   bus    : tuple_unpack_if.slave (input stream, output stream, counters)
module tuple_unpack #(
    parameter int SCALING         = 32,
    parameter int DATAIN_WIDTH    = 11,
    parameter int RES_SHORT_WIDTH = 24,
    parameter int TUPLE_WIDTH     = 4 * RES_SHORT_WIDTH,
    parameter int CNT_WIDTH       = 32
) (
    input  logic           clk,
    input  logic           resetn,
    tuple_unpack_if.slave  bus
);
    localparam int R      = RES_SHORT_WIDTH;
    localparam int D      = DATAIN_WIDTH;
    localparam int MEAN_W = D + SCALING + 1;
    localparam int VAR_W  = 2 * D + SCALING + 1;
    localparam int VSH    = 2 * D + SCALING - R;

    generate
        if ((2 * D + SCALING < R) || (R < D) || (TUPLE_WIDTH != 4 * R)) begin : g_bad_widths
            $error("tuple_unpack: need 2*DATAIN_WIDTH+SCALING >= RES_SHORT_WIDTH >= DATAIN_WIDTH and TUPLE_WIDTH = 4*RES_SHORT_WIDTH");
        end
    endgenerate

    typedef struct packed {
        logic [R-1:0]      syn;
        logic [R-1:0]      pkt;
        logic [MEAN_W-1:0] mean;
        logic [VAR_W-1:0]  variance;
        logic              fmt_err;
    } word_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t               state, state_next;
    word_t                dec, main_q, skid_q;
    logic                 ready_q;
    logic                 out_valid;
    logic                 accept, pop;
    logic                 load_main_in, load_skid, load_main_skid;
    logic                 fmt_in;
    logic [R-1:0]         mean_field, var_field;
    logic [CNT_WIDTH-1:0] tuple_count_q, err_count_q;

    assign mean_field = bus.tuple_in[2*R-1:R];
    assign var_field  = bus.tuple_in[R-1:0];

    generate
        if (R > D) begin : g_fmt
            assign fmt_in = |mean_field[R-1:D];
        end else begin : g_no_fmt
            assign fmt_in = 1'b0;
        end
    endgenerate

    // Combinational decode; upper mean bits are dropped even when flagged.
    always_comb begin
        dec          = '0;
        dec.syn      = bus.tuple_in[4*R-1:3*R];
        dec.pkt      = bus.tuple_in[3*R-1:2*R];
        dec.mean     = MEAN_W'(mean_field[D-1:0]) << SCALING;
        dec.variance = VAR_W'(var_field) << VSH;
        dec.fmt_err  = fmt_in;
    end

    assign out_valid = (state != EMPTY);
    assign accept    = bus.tuple_valid & ready_q;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_skid      = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // ready is registered from the next state so it is low exactly while both
    // entries are occupied, and rises on the first edge out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
            if (load_main_in) begin
                main_q <= dec;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tuple_count_q <= '0;
            err_count_q   <= '0;
        end else if (accept) begin
            if (tuple_count_q != '1) begin
                tuple_count_q <= tuple_count_q + CNT_WIDTH'(1);
            end
            if (dec.fmt_err && (err_count_q != '1)) begin
                err_count_q <= err_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.tuple_ready = ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.syn_cnt     = main_q.syn;
    assign bus.pkt_cnt     = main_q.pkt;
    assign bus.mean        = main_q.mean;
    assign bus.variance    = main_q.variance;
    assign bus.fmt_err     = main_q.fmt_err;
    assign bus.tuple_count = tuple_count_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_tuple_unpack.sv
// tb_tuple_unpack
//   Directed bench for tuple_unpack. A queue-based model predicts every
//   output from the field rules; a compare process checks the DUT against it
//   on each falling edge, and directed steps add hand-computed literals.
module tb_tuple_unpack;
    logic clk    = 1'b0;
    logic resetn = 1'b1;

    int nchecks = 0;
    int nerrors = 0;
    int cyc     = 0;

    tuple_unpack_if #(
        .SCALING(32), .DATAIN_WIDTH(11), .RES_SHORT_WIDTH(24),
        .TUPLE_WIDTH(96), .CNT_WIDTH(32)
    ) bus ();

    tuple_unpack #(
        .SCALING(32), .DATAIN_WIDTH(11), .RES_SHORT_WIDTH(24),
        .TUPLE_WIDTH(96), .CNT_WIDTH(32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] syn;
        logic [23:0] pkt;
        logic [63:0] mean;
        logic [63:0] variance;
        logic        fmt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_tc    = '0;
    logic [31:0] m_ec    = '0;
    logic        m_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Field rules written as plain arithmetic: low 11 mean bits scaled by
    // 2^32, variance field scaled by 2^30, error when mean field >= 2^11.
    function automatic exp_t make_exp(input logic [95:0] t);
        exp_t e;
        longint unsigned mf, vf;
        e.syn      = t[95:72];
        e.pkt      = t[71:48];
        mf         = longint'(t[47:24]);
        vf         = longint'(t[23:0]);
        e.mean     = (mf % 64'd2048) * 64'd4294967296;
        e.variance = vf * 64'd1073741824;
        e.fmt      = (mf >= 64'd2048);
        return e;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            m_tc    = '0;
            m_ec    = '0;
            m_ready = 1'b0;
        end else begin
            logic acc, pop;
            exp_t e;
            acc = bus.tuple_valid && m_ready;
            pop = (q.size() != 0) && bus.out_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e = make_exp(bus.tuple_in);
                q.push_back(e);
                if (m_tc != 32'hFFFF_FFFF) m_tc = m_tc + 32'd1;
                if (e.fmt && (m_ec != 32'hFFFF_FFFF)) m_ec = m_ec + 32'd1;
            end
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("out_valid",   64'(bus.out_valid),   64'(q.size() != 0));
        chk("tuple_ready", 64'(bus.tuple_ready), 64'(m_ready));
        chk("tuple_count", 64'(bus.tuple_count), 64'(m_tc));
        chk("err_count",   64'(bus.err_count),   64'(m_ec));
        if (q.size() != 0) begin
            chk("syn_cnt",  64'(bus.syn_cnt),  64'(q[0].syn));
            chk("pkt_cnt",  64'(bus.pkt_cnt),  64'(q[0].pkt));
            chk("mean",     64'(bus.mean),     q[0].mean);
            chk("variance", 64'(bus.variance), q[0].variance);
            chk("fmt_err",  64'(bus.fmt_err),  64'(q[0].fmt));
        end
        if (!resetn) begin
            chk("rst_syn",  64'(bus.syn_cnt),  64'd0);
            chk("rst_mean", 64'(bus.mean),     64'd0);
            chk("rst_var",  64'(bus.variance), 64'd0);
        end
    end

    task automatic do_reset();
        bus.tuple_valid = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Holds the word on the bus until the DUT takes it (bounded wait).
    task automatic send(input logic [23:0] s, input logic [23:0] p,
                        input logic [23:0] m, input logic [23:0] v);
        int n;
        n = 0;
        bus.tuple_valid = 1'b1;
        bus.tuple_in    = {s, p, m, v};
        while (!bus.tuple_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                nchecks++;
                nerrors++;
                $display("FAIL send_timeout: got tuple_ready=0 expected 1 within 50 cycles");
                bus.tuple_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 bus.tuple_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        bus.tuple_valid = 1'b0;
        bus.tuple_in    = '0;
        bus.out_ready   = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready",  64'(bus.tuple_ready), 64'd0);
        chk("reset_count",  64'(bus.tuple_count), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(bus.tuple_ready), 64'd1);

        // 1: single word
        send(24'd5, 24'd100, 24'h000123, 24'h000400);
        chk("t1_valid",    64'(bus.out_valid),   64'd1);
        chk("t1_syn",      64'(bus.syn_cnt),     64'd5);
        chk("t1_pkt",      64'(bus.pkt_cnt),     64'd100);
        chk("t1_mean",     64'(bus.mean),        64'h0000_0123_0000_0000);
        chk("t1_variance", 64'(bus.variance),    64'h0000_0100_0000_0000);
        chk("t1_fmt",      64'(bus.fmt_err),     64'd0);
        chk("t1_count",    64'(bus.tuple_count), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // 2: backpressure
        bus.out_ready = 1'b0;
        send(24'd11, 24'd1, 24'h000010, 24'h000001);
        send(24'd22, 24'd2, 24'h000020, 24'h000002);
        chk("t2_ready_full", 64'(bus.tuple_ready), 64'd0);
        chk("t2_count",      64'(bus.tuple_count), 64'd3);
        bus.tuple_valid = 1'b1;
        bus.tuple_in    = {24'd33, 24'd3, 24'h000030, 24'h000003};
        repeat (3) @(posedge clk);
        #1;
        chk("t2_stall_syn",   64'(bus.syn_cnt),     64'd11);
        chk("t2_stall_count", 64'(bus.tuple_count), 64'd3);
        bus.out_ready = 1'b1;
        send(24'd33, 24'd3, 24'h000030, 24'h000003);
        repeat (4) @(posedge clk);
        #1 chk("t2_drained", 64'(bus.out_valid), 64'd0);

        // 3: streaming
        do_reset();
        @(posedge clk);
        #1 c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send(24'(i), 24'(i * 3), 24'((i * 37) % 4096), 24'(i * 12345));
        end
        chk("t3_cycles", 64'(cyc - c0), 64'd100);
        chk("t3_count",  64'(bus.tuple_count), 64'd100);
        repeat (3) @(posedge clk);
        #1;

        // 4: malformed mean
        do_reset();
        @(posedge clk);
        #1 send(24'd7, 24'd8, 24'h001800, 24'h000010);
        chk("t4_fmt",    64'(bus.fmt_err),     64'd1);
        chk("t4_mean",   64'(bus.mean),        64'd0);
        chk("t4_err",    64'(bus.err_count),   64'd1);
        chk("t4_count",  64'(bus.tuple_count), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // 5: saturation
        do_reset();
        @(posedge clk);
        #1;
        force dut.tuple_count_q = 32'hFFFF_FFFE;
        m_tc = 32'hFFFF_FFFE;
        #1 release dut.tuple_count_q;
        for (int i = 0; i < 3; i++) begin
            send(24'(40 + i), 24'd0, 24'h000001, 24'h000001);
        end
        chk("t5_sat", 64'(bus.tuple_count), 64'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;

        // 6: reset while both entries are full
        bus.out_ready = 1'b0;
        send(24'd61, 24'd1, 24'h000061, 24'h000001);
        send(24'd62, 24'd2, 24'h000062, 24'h000002);
        chk("t6_full_valid", 64'(bus.out_valid),   64'd1);
        chk("t6_full_ready", 64'(bus.tuple_ready), 64'd0);
        resetn = 1'b0;
        #1 chk("t6_valid_now", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_stale", 64'(bus.out_valid),   64'd0);
        chk("t6_count",    64'(bus.tuple_count), 64'd0);
        chk("t6_err",      64'(bus.err_count),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
